// File: rtl/rtc_set_ctrl.sv
// Sequencing for the BCD timekeeping core: one-second tick prescaler plus the
// button-driven set-mode FSM. Define RTC_ALARM_EN to add alarm editing and alarm_hit.
module rtc_set_ctrl #(
    parameter int TICK_DIV = 10,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [7:0] cur_hr,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic       tick,
    output logic       load,
    output logic [7:0] ld_hr,
    output logic [7:0] ld_min,
    output logic [7:0] ld_sec,
    output logic [1:0] edit_field
`ifdef RTC_ALARM_EN
    ,
    output logic       alarm_hit
`endif
);

    // state      | meaning
    // RUN        | normal timekeeping, prescaler running
    // SET_HR     | editing shadow hours
    // SET_MIN    | editing shadow minutes
    // SET_SEC    | editing shadow seconds
    // SET_AL_HR  | editing alarm hours (alarm build only)
    // SET_AL_MIN | editing alarm minutes (alarm build only)
    // COMMIT     | one cycle; load pulse follows on exit
    typedef enum logic [2:0] {
        RUN,
        SET_HR,
        SET_MIN,
        SET_SEC,
`ifdef RTC_ALARM_EN
        SET_AL_HR,
        SET_AL_MIN,
`endif
        COMMIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             load_q, load_d;
    logic [1:0]       edit_q, edit_d;
    logic [7:0]       sh_hr_q, sh_hr_d;
    logic [7:0]       sh_min_q, sh_min_d;
    logic [7:0]       sh_sec_q, sh_sec_d;
    logic [7:0]       ld_hr_q, ld_hr_d;
    logic [7:0]       ld_min_q, ld_min_d;
    logic [7:0]       ld_sec_q, ld_sec_d;
    logic             inc_ok;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        if (v == max_v)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

`ifdef RTC_ALARM_EN
    logic [7:0] al_hr_q, al_hr_d;
    logic [7:0] al_min_q, al_min_d;
    logic       al_match, al_match_q, alarm_hit_q;
`endif

    // mode_btn takes priority; a simultaneous inc is dropped
    assign inc_ok = inc_btn && !mode_btn;

    always_comb begin
        state_d  = state_q;
        sh_hr_d  = sh_hr_q;
        sh_min_d = sh_min_q;
        sh_sec_d = sh_sec_q;
`ifdef RTC_ALARM_EN
        al_hr_d  = al_hr_q;
        al_min_d = al_min_q;
`endif
        case (state_q)
            RUN: begin
                if (mode_btn) begin
                    state_d  = SET_HR;
                    sh_hr_d  = cur_hr;
                    sh_min_d = cur_min;
                    sh_sec_d = cur_sec;
                end
            end
            SET_HR: begin
                if (mode_btn)    state_d = SET_MIN;
                else if (inc_ok) sh_hr_d = bcd_inc(sh_hr_q, 8'h23);
            end
            SET_MIN: begin
                if (mode_btn)    state_d  = SET_SEC;
                else if (inc_ok) sh_min_d = bcd_inc(sh_min_q, 8'h59);
            end
            SET_SEC: begin
`ifdef RTC_ALARM_EN
                if (mode_btn)    state_d  = SET_AL_HR;
`else
                if (mode_btn)    state_d  = COMMIT;
`endif
                else if (inc_ok) sh_sec_d = bcd_inc(sh_sec_q, 8'h59);
            end
`ifdef RTC_ALARM_EN
            SET_AL_HR: begin
                if (mode_btn)    state_d = SET_AL_MIN;
                else if (inc_ok) al_hr_d = bcd_inc(al_hr_q, 8'h23);
            end
            SET_AL_MIN: begin
                if (mode_btn)    state_d  = COMMIT;
                else if (inc_ok) al_min_d = bcd_inc(al_min_q, 8'h59);
            end
`endif
            COMMIT:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Tick only fires while staying in RUN, so it never overlaps an edit or the load pulse
    always_comb begin
        cnt_d  = '0;
        tick_d = 1'b0;
        if (state_q == RUN && state_d == RUN) begin
            if (cnt_q == CNT_TC) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end
    end

    // Load is issued on the COMMIT exit edge, aligned with prescaler restart at 0
    always_comb begin
        load_d   = (state_q == COMMIT);
        ld_hr_d  = ld_hr_q;
        ld_min_d = ld_min_q;
        ld_sec_d = ld_sec_q;
        if (load_d) begin
            ld_hr_d  = sh_hr_q;
            ld_min_d = sh_min_q;
            ld_sec_d = sh_sec_q;
        end
        case (state_d)
            SET_HR:     edit_d = 2'd1;
            SET_MIN:    edit_d = 2'd2;
            SET_SEC:    edit_d = 2'd3;
`ifdef RTC_ALARM_EN
            SET_AL_HR:  edit_d = 2'd1;
            SET_AL_MIN: edit_d = 2'd2;
`endif
            default:    edit_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            load_q   <= 1'b0;
            edit_q   <= 2'd0;
            sh_hr_q  <= 8'h00;
            sh_min_q <= 8'h00;
            sh_sec_q <= 8'h00;
            ld_hr_q  <= 8'h00;
            ld_min_q <= 8'h00;
            ld_sec_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            load_q   <= load_d;
            edit_q   <= edit_d;
            sh_hr_q  <= sh_hr_d;
            sh_min_q <= sh_min_d;
            sh_sec_q <= sh_sec_d;
            ld_hr_q  <= ld_hr_d;
            ld_min_q <= ld_min_d;
            ld_sec_q <= ld_sec_d;
        end
    end

`ifdef RTC_ALARM_EN
    assign al_match = (state_q == RUN) && (cur_hr == al_hr_q) &&
                      (cur_min == al_min_q) && (cur_sec == 8'h00);

    always_ff @(posedge clk) begin
        if (!rst) begin
            al_hr_q     <= 8'h00;
            al_min_q    <= 8'h00;
            al_match_q  <= 1'b0;
            alarm_hit_q <= 1'b0;
        end else begin
            al_hr_q     <= al_hr_d;
            al_min_q    <= al_min_d;
            al_match_q  <= al_match;
            alarm_hit_q <= al_match && !al_match_q;
        end
    end

    assign alarm_hit = alarm_hit_q;
`endif

    assign tick       = tick_q;
    assign load       = load_q;
    assign ld_hr      = ld_hr_q;
    assign ld_min     = ld_min_q;
    assign ld_sec     = ld_sec_q;
    assign edit_field = edit_q;

endmodule
